ramworks_slot_arb: RTL and testbench

RAMWORKS_SLOT_ARB -- requirements
Module: ramworks_slot_arb

---
 rtl/ramworks_slot_arb.sv | 192 +++++++++++++++++++
 tb/tb_ramworks_slot_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ramworks_slot_arb.sv
// ramworks_slot_arb
// ------------------------------------------------------------------
// Hands out the auxiliary DRAM slots of an Apple II RamWorks-style card.
// The high half of PHI1 is the video slot and the low half is the CPU slot.
// Each detected slot edge produces one registered, one-hot grant that is
// GLEN cycles wide. The grant goes to the CPU, to video, to refresh, or to
// no one. A free-running prescaler counts refresh debt, and video slots pay
// that debt back when no video fetch needs the slot, or always once the debt
// is urgent.
//
// Optional feature macro: REF_BURST_EN
//   Defined   : an idle CPU slot (nEN80 high) with debt pending is used
//               for refresh as well.
//   Undefined : refresh happens in video slots only.
//
// Parameters
//   REF_DIV : C14M cycles per refresh tick
//   URGENT  : debt level at which refresh pre-empts a video fetch
//   GLEN    : grant pulse width in C14M cycles
//
// Ports
//   C14M     in   14 MHz clock; every register updates on its rising edge
//   nRESET   in   asynchronous active-low reset
//   PHI1     in   CPU phase 1, asynchronous to C14M
//   nEN80    in   active-low CPU request for auxiliary DRAM
//   VidEN    in   auxiliary video fetch wanted in the video slot
//   GntCPU   out  CPU slot grant
//   GntVid   out  video slot grant
//   GntRef   out  refresh grant
//   RefRow   out  [7:0] next refresh row
//   RefDebt  out  [2:0] pending refresh count (saturates at 7)
//   RefOvf   out  sticky: a tick arrived while the debt was already 7
//   SlotPh   out  current half, 1 = video, 0 = CPU
// ------------------------------------------------------------------
module ramworks_slot_arb #(
  parameter int REF_DIV = 224,
  parameter int URGENT  = 4,
  parameter int GLEN    = 5
) (
  input  logic       C14M,
  input  logic       nRESET,
  input  logic       PHI1,
  input  logic       nEN80,
  input  logic       VidEN,
  output logic       GntCPU,
  output logic       GntVid,
  output logic       GntRef,
  output logic [7:0] RefRow,
  output logic [2:0] RefDebt,
  output logic       RefOvf,
  output logic       SlotPh
);

  localparam int PRE_W = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
  localparam int GW    = (GLEN > 1) ? $clog2(GLEN + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(REF_DIV - 1);
  localparam logic [GW-1:0]    GLEN_LD = GW'(GLEN - 1);
  localparam logic [2:0]       URG = 3'(URGENT);

  typedef struct packed {
    logic cpu;
    logic vid;
    logic rfsh;
  } gnt_t;

  // PHI1 synchronizer plus history flop
  logic r_s1, r_s2, r_s3;
  logic w_edge;

  logic [PRE_W-1:0] r_pre;
  logic             w_tick;

  logic [7:0] r_row;
  logic [2:0] r_debt;
  logic       r_ovf;
  logic       r_slot;

  gnt_t          r_gnt;
  gnt_t          w_dec;
  logic [GW-1:0] r_glen;

  logic w_pend;
  logic w_urgent;
  logic w_take;

  always_ff @(posedge C14M or negedge nRESET) begin
    if (!nRESET) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= PHI1;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // A slot edge is visible the cycle after PHI1 reaches s2, so the decision
  // is registered two edges after PHI1 was first captured in s1.
  assign w_edge = r_s2 ^ r_s3;

  // ------------------------------------------------------------------
  // Refresh prescaler
  // ------------------------------------------------------------------
  assign w_tick = (r_pre == PRE_TC);

  always_ff @(posedge C14M or negedge nRESET) begin
    if (!nRESET)     r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + PRE_W'(1);
  end

  // ------------------------------------------------------------------
  // Slot decision. The inputs are sampled only at the decision edge.
  // A refresh decision always needs a nonzero debt, so the debt cannot
  // underflow even if URGENT is set to 0.
  // ------------------------------------------------------------------
  assign w_pend   = (r_debt != 3'd0);
  assign w_urgent = w_pend && (r_debt >= URG);

  always_comb begin
    w_dec = '0;
    if (r_s2) begin
      if (w_urgent)    w_dec.rfsh = 1'b1;
      else if (VidEN)  w_dec.vid  = 1'b1;
      else if (w_pend) w_dec.rfsh = 1'b1;
    end else begin
      if (!nEN80)      w_dec.cpu  = 1'b1;
`ifdef REF_BURST_EN
      else if (w_pend) w_dec.rfsh = 1'b1;
`endif
    end
  end

  assign w_take = w_edge & w_dec.rfsh;

  // ------------------------------------------------------------------
  // Grant pulse: it is loaded on each slot edge and runs for GLEN cycles.
  // A new edge reloads it directly, so no gap cycle appears between grants.
  // ------------------------------------------------------------------
  always_ff @(posedge C14M or negedge nRESET) begin
    if (!nRESET) begin
      r_gnt  <= '0;
      r_glen <= '0;
    end else if (w_edge) begin
      r_gnt  <= w_dec;
      r_glen <= GLEN_LD;
    end else if (r_gnt != '0) begin
      if (r_glen == '0) r_gnt  <= '0;
      else              r_glen <= r_glen - GW'(1);
    end
  end

  always_ff @(posedge C14M or negedge nRESET) begin
    if (!nRESET)     r_slot <= 1'b0;
    else if (w_edge) r_slot <= r_s2;
  end

  // ------------------------------------------------------------------
  // Refresh debt and row. If a tick and a refresh land on the same edge,
  // they cancel out, so the overflow check is skipped for that case.
  // ------------------------------------------------------------------
  always_ff @(posedge C14M or negedge nRESET) begin
    if (!nRESET) begin
      r_debt <= 3'd0;
      r_ovf  <= 1'b0;
    end else begin
      case ({w_tick, w_take})
        2'b10: begin
          if (r_debt == 3'd7) r_ovf  <= 1'b1;
          else                r_debt <= r_debt + 3'd1;
        end
        2'b01:   r_debt <= r_debt - 3'd1;
        default: r_debt <= r_debt;
      endcase
    end
  end

  always_ff @(posedge C14M or negedge nRESET) begin
    if (!nRESET)     r_row <= 8'd0;
    else if (w_take) r_row <= r_row + 8'd1;
  end

  assign GntCPU  = r_gnt.cpu;
  assign GntVid  = r_gnt.vid;
  assign GntRef  = r_gnt.rfsh;
  assign RefRow  = r_row;
  assign RefDebt = r_debt;
  assign RefOvf  = r_ovf;
  assign SlotPh  = r_slot;

endmodule

// File: tb/tb_ramworks_slot_arb.sv
// Directed bench for ramworks_slot_arb. It uses REF_DIV = 64, so refresh
// ticks land on edges 64, 128, ... counted from each reset release.
// The grant vector is shown as {CPU, Vid, Ref}.
module tb_ramworks_slot_arb;

  localparam int RD = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       phi1, nen80, viden;
  logic       gcpu, gvid, gref;
  logic [7:0] row;
  logic [2:0] debt;
  logic       ovf, slot;

  ramworks_slot_arb #(.REF_DIV(RD), .URGENT(4), .GLEN(5)) dut (
    .C14M(clk), .nRESET(rst_n), .PHI1(phi1), .nEN80(nen80), .VidEN(viden),
    .GntCPU(gcpu), .GntVid(gvid), .GntRef(gref),
    .RefRow(row), .RefDebt(debt), .RefOvf(ovf), .SlotPh(slot)
  );

  always #5 clk = ~clk;

  wire [2:0] gnt = {gcpu, gvid, gref};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    rst_n = 1'b0; phi1 = 1'b0; nen80 = 1'b1; viden = 1'b0;
    step(); step(); step();
    chk("rst_gnt",  32'(gnt),  32'd0);
    chk("rst_row",  32'(row),  32'd0);
    chk("rst_debt", 32'(debt), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    chk("rst_slot", 32'(slot), 32'd0);
    rst_n = 1'b1; cyc = 0;

    // With no PHI1 edge, no grant is issued.
    step_to(5);
    chk("idle_after_rst", 32'(gnt), 32'd0);

    // Alternating slots, 7 clocks per half: video, CPU, video, CPU.
    nen80 = 1'b0; viden = 1'b1;
    for (int it = 0; it < 4; it++) begin
      phi1 = (it % 2 == 0);
      step(); chk("alt_off1", 32'(gnt), 32'd0);
      step(); chk("alt_lat",  32'(gnt), 32'd0);
      step(); chk("alt_gnt",  32'(gnt), (it % 2 == 0) ? 32'b010 : 32'b100);
              chk("alt_slot", 32'(slot), (it % 2 == 0) ? 32'd1 : 32'd0);
      step(); step(); step(); step();
      chk("alt_hold", 32'(gnt), (it % 2 == 0) ? 32'b010 : 32'b100);
    end
    step(); chk("alt_end", 32'(gnt), 32'd0);     // edge 34

    // A short slot is replaced with no gap, and the new grant is full length.
    step_to(35); phi1 = 1'b1;
    step_to(38); chk("short_vid", 32'(gnt), 32'b010);
    phi1 = 1'b0;
    step_to(40); chk("short_vid2", 32'(gnt), 32'b010);
    step_to(41); chk("nogap_cpu",  32'(gnt), 32'b100);
    step_to(45); chk("nogap_hold", 32'(gnt), 32'b100);
    step_to(46); chk("nogap_end",  32'(gnt), 32'd0);

    // Urgent refresh takes the video slot away from video.
    nen80 = 1'b1; viden = 1'b1;
    step_to(260); chk("debt4", 32'(debt), 32'd4);
    phi1 = 1'b1;
    step_to(263);
    chk("urg_gnt",  32'(gnt),  32'b001);
    chk("urg_debt", 32'(debt), 32'd3);
    chk("urg_row",  32'(row),  32'd1);
    step_to(267); chk("urg_hold", 32'(gnt), 32'b001);

    // Three CPU slots with no CPU request, debt 3.
    for (int i = 0; i < 3; i++) begin
      phi1 = 1'b0;
      step(); step(); step();
`ifdef REF_BURST_EN
      chk("cpu_burst_gnt",  32'(gnt),  32'b001);
      chk("cpu_burst_debt", 32'(debt), 32'(2 - i));
`else
      chk("cpu_idle_gnt",  32'(gnt),  32'd0);
      chk("cpu_idle_debt", 32'(debt), 32'd3);
`endif
      step(); step(); step(); step();
      phi1 = 1'b1;
      step(); step(); step();
      chk("vid_gnt", 32'(gnt), 32'b010);
      step(); step(); step(); step();
    end
`ifdef REF_BURST_EN
    chk("burst_row", 32'(row), 32'd4);
`else
    chk("noburst_row", 32'(row), 32'd1);
`endif

    // When PHI1 stops, the grants end and the block stays idle.
    step_to(315); chk("stall_idle", 32'(gnt), 32'd0);

    // Reset on grant cycle 2 drops the grant asynchronously.
    phi1 = 1'b0; nen80 = 1'b0;
    step_to(318); chk("pre_rst_gnt", 32'(gnt), 32'b100);
    step_to(319);
    rst_n = 1'b0; #1;
    chk("async_gnt",  32'(gnt),  32'd0);
    chk("async_row",  32'(row),  32'd0);
    chk("async_debt", 32'(debt), 32'd0);
    chk("async_slot", 32'(slot), 32'd0);
    step(); step();
    rst_n = 1'b1; cyc = 0;

    // PHI1 is held low. A CPU request gives no grant, and the debt saturates.
    step_to(10);  chk("hold_nogrant", 32'(gnt), 32'd0);
    step_to(450);
    chk("sat_debt", 32'(debt), 32'd7);
    chk("sat_ovf0", 32'(ovf),  32'd0);
    step_to(514);
    chk("ovf_debt", 32'(debt), 32'd7);
    chk("ovf_set",  32'(ovf),  32'd1);
    chk("ovf_gnt",  32'(gnt),  32'd0);
    phi1 = 1'b1;                                    // the first grant follows this edge
    step_to(516); chk("first_lat", 32'(gnt), 32'd0);
    step_to(517);
    chk("first_gnt",  32'(gnt),  32'b001);
    chk("first_debt", 32'(debt), 32'd6);
    chk("first_row",  32'(row),  32'd1);
    chk("ovf_sticky", 32'(ovf),  32'd1);

    rst_n = 1'b0; #1;
    chk("ovf_clr", 32'(ovf), 32'd0);
    phi1 = 1'b0; viden = 1'b0; nen80 = 1'b1;
    step(); step();
    rst_n = 1'b1; cyc = 0;

    // Walk RefRow up to 255 with one refresh per tick.
    for (int j = 1; j <= 255; j++) begin
      step_to(RD * j);      phi1 = 1'b1;
      step_to(RD * j + 7);  phi1 = 1'b0;
    end
    step_to(RD * 257 + 2);
    chk("walk_row",  32'(row),  32'd255);
    chk("walk_debt", 32'(debt), 32'd2);
    // The video decision coincides with the tick at edge 64*258.
    step_to(RD * 258 - 3); phi1 = 1'b1;
    step_to(RD * 258);
    chk("coin_gnt",  32'(gnt),  32'b001);
    chk("coin_debt", 32'(debt), 32'd2);
    chk("coin_row",  32'(row),  32'd0);
    chk("coin_ovf",  32'(ovf),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
